// File: rtl/twos_comp_to_abs_serial.sv
// ---------------------------------------------------------------------------
// twos_comp_to_abs_serial
//
// Bit-serial converter from an N-bit two's complement word to sign-magnitude
// form: an unsigned magnitude |x| plus a sign bit. This is the inverse of the
// sign-magnitude -> two's complement path in the datapath. It feeds the
// absolute-value / compare logic, which needs magnitudes.
//
// Algorithm (LSB first): for a negative word, copy bits up to and including
// the first 1. After that, invert the remaining bits. That is -x computed one
// bit per cycle, with no carry chain. A non-negative word passes through
// unchanged.
//
// Only one word is in flight at a time. The flow is:
//   IDLE  -> accept a word
//   SHIFT -> N cycles, one bit per cycle
//   DONE  -> hold the result until it is taken
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer offers a word on 'in'
//   in_ready   block can accept a word (combinational: IDLE and not in reset)
//   in         N-bit two's complement input word
//   out_valid  abs_out / sign_out hold a finished result
//   out_ready  consumer takes the result
//   abs_out    N-bit unsigned magnitude |in|
//   sign_out   1 when the input word was negative
// ---------------------------------------------------------------------------
module twos_comp_to_abs_serial #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] abs_out,
  output logic         sign_out
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   shift_reg;   // remaining input bits; bit 0 is processed next
  logic [CNT_W-1:0] cnt;       // index of the bit being processed
  logic           found_one;   // a 1 has already been copied (negative words)
  logic           res_bit;     // result bit produced this SHIFT cycle

  // Invert a bit only for a negative word, and only after its first 1 has
  // been seen. This is the "copy up to the first 1, then invert" rule.
  // NOTE: every signal written in always_comb gets a value on every path,
  // so no latch is inferred.
  always_comb begin
    res_bit = shift_reg[0];
    if (sign_out && found_one) begin
      res_bit = ~shift_reg[0];
    end
  end

  // Only the acceptance handshake is combinational. It is held low during
  // reset, so a word offered in the reset cycle is not considered taken.
  assign in_ready = (state == IDLE) && !rst;

  // NOTE: all state updates use non-blocking assignments. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      found_one <= 1'b0;
      out_valid <= 1'b0;
      abs_out   <= '0;
      sign_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // 'in' is sampled only here; later changes on 'in' are ignored.
          if (in_valid && in_ready) begin
            shift_reg <= in;
            sign_out  <= in[N-1];
            cnt       <= '0;
            found_one <= 1'b0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          // The result enters from the MSB side. After N shifts, the first
          // (LSB) result bit has reached abs_out[0].
          abs_out   <= {res_bit, abs_out[N-1:1]};
          shift_reg <= {1'b0, shift_reg[N-1:1]};
          found_one <= found_one | shift_reg[0];
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // The result stays frozen until the consumer takes it. abs_out and
          // sign_out then keep their values until the next capture.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_comp_to_abs_serial.sv
// ---------------------------------------------------------------------------
// tb_twos_comp_to_abs_serial
//
// Self-checking bench for twos_comp_to_abs_serial with N=5.
// Expected {sign, magnitude} pairs are pushed to a queue when a word is
// accepted. They are popped and compared when the DUT hands over a result.
// Inputs are driven 1 time unit after the rising edge. Outputs and
// handshakes are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_twos_comp_to_abs_serial;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] abs_out;
  logic         sign_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N:0] sb_q[$];   // expected {sign, abs}

  twos_comp_to_abs_serial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .abs_out   (abs_out),
    .sign_out  (sign_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sign is the MSB; magnitude is -x mod 2^N when negative.
  function automatic logic [N:0] model(input logic [N-1:0] x);
    logic [N-1:0] m;
    m = x[N-1] ? (~x + 1'b1) : x;
    return {x[N-1], m};
  endfunction

  // Offer a word and hold it until accepted. The expected result is pushed
  // at the accept edge. Returns 1 time unit after that edge.
  task automatic send(input logic [N-1:0] x);
    int wait_cyc;
    in       = x;
    in_valid = 1'b1;
    wait_cyc = 0;
    @(negedge clk);
    while (!in_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb_q.push_back(model(x));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called on a falling edge where out_valid && out_ready holds.
  task automatic compare_out(input string tag);
    logic [N:0] exp;
    if (sb_q.size() == 0) begin
      check({tag, "_unexpected"}, {26'd0, sign_out, abs_out}, 32'hFFFF_FFFF);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {26'd0, sign_out, abs_out}, {26'd0, exp});
    end
  endtask

  // Wait for a result with out_ready=1 and check it.
  // Returns 1 time unit after the release edge.
  task automatic recv(input string tag);
    int wait_cyc;
    out_ready = 1'b1;
    wait_cyc  = 0;
    @(negedge clk);
    while (!out_valid && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!out_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    else            compare_out(tag);
    @(posedge clk);
    #1;
  endtask

  // Convert one word and check its result.
  task automatic convert(input logic [N-1:0] x, input string tag);
    send(x);
    recv(tag);
  endtask

  initial begin : main
    int lat;
    int rcv;
    int cyc;
    logic [N:0] held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in        = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_abs_sign",  {26'd0, sign_out, abs_out}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: +5 with latency measurement
    send(5'b00101);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, 32'd5);
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    recv("pos5");

    // 2, 3: negative, -1, most negative, zero
    convert(5'b11011, "neg5");
    convert(5'b11111, "neg1");
    convert(5'b10000, "neg16");
    convert(5'b00000, "zero");
    convert(5'b01111, "pos15");

    // 4: back-pressure, outputs hold, offered words ignored
    out_ready = 1'b0;
    send(5'b10011);
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    held = (sb_q.size() != 0) ? sb_q[0] : '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 in_valid = 1'b1;
      in = N'($urandom);
      @(negedge clk);
      check("bp_hold",     {26'd0, sign_out, abs_out}, {26'd0, held});
      check("bp_in_ready", {30'd0, in_ready, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    recv("bp_result");
    check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    @(negedge clk);
    check("bp_no_extra", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // 5: reset during the third SHIFT cycle
    in       = 5'b10110;
    in_valid = 1'b1;
    @(posedge clk);                 // accept edge E0 (DUT is IDLE)
    #1 in_valid = 1'b0;
    in = 5'b00000;
    @(posedge clk);                 // SHIFT cycle 1
    @(posedge clk);                 // SHIFT cycle 2
    #1 rst = 1'b1;
    @(posedge clk);                 // third SHIFT cycle is reset instead
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_abs",       {27'd0, abs_out}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    convert(5'b01111, "post_rst");

    // 6: 200 random words, random gaps and back-pressure
    rcv = 0;
    fork
      begin : driver
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 send(N'($urandom));
        end
      end
      begin : monitor
        cyc = 0;
        while (rcv < 200 && cyc < 20000) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
          @(negedge clk);
          if (out_valid && out_ready) begin
            compare_out("rand");
            rcv++;
          end
          cyc++;
        end
        if (rcv < 200) check("rand_timeout", rcv, 32'd200);
      end
    join
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rand_drained", sb_q.size(), 32'd0);
    check("rand_no_dup",  {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
